// File: rtl/shift_opnd_stage_if.sv
// ---------------------------------------------------------------------------
// shift_opnd_stage_if
// Bundles the ID-side operand bus, pipeline control, the two forwarding
// writer ports and the registered EX-side shifter operands of the ID/EX
// shift operand stage.
//
// Signals:
//   id_*           decoded shift instruction and register-file reads
//   stall, flush   pipeline control for the stage
//   exmem_wr_*     EX/MEM register writer (highest forwarding priority)
//   memwb_wr_*     MEM/WB register writer
//   ex_*           registered shifter operands and pass-down fields
//
// Modports:
//   master  drives the ID/control/writer side, observes the ex_* outputs
//   slave   the stage itself
// ---------------------------------------------------------------------------
interface shift_opnd_stage_if #(
    parameter int DW = 16,
    parameter int RW = 3,
    parameter int CW = 4
);
    logic          id_valid;
    logic [1:0]    id_op;
    logic [RW-1:0] id_rs_idx;
    logic [DW-1:0] id_rs_val;
    logic [RW-1:0] id_rt_idx;
    logic [DW-1:0] id_rt_val;
    logic          id_cnt_from_reg;
    logic [CW-1:0] id_cnt_imm;
    logic [RW-1:0] id_rd_idx;

    logic          stall;
    logic          flush;

    logic          exmem_wr_en;
    logic [RW-1:0] exmem_wr_idx;
    logic [DW-1:0] exmem_wr_data;
    logic          memwb_wr_en;
    logic [RW-1:0] memwb_wr_idx;
    logic [DW-1:0] memwb_wr_data;

    logic          ex_valid;
    logic [DW-1:0] ex_in;
    logic [CW-1:0] ex_cnt;
    logic [1:0]    ex_op;
    logic [RW-1:0] ex_rd_idx;
    logic [1:0]    ex_fwd_rs;

    modport master (
        output id_valid, id_op, id_rs_idx, id_rs_val, id_rt_idx, id_rt_val,
               id_cnt_from_reg, id_cnt_imm, id_rd_idx,
               stall, flush,
               exmem_wr_en, exmem_wr_idx, exmem_wr_data,
               memwb_wr_en, memwb_wr_idx, memwb_wr_data,
        input  ex_valid, ex_in, ex_cnt, ex_op, ex_rd_idx, ex_fwd_rs
    );

    modport slave (
        input  id_valid, id_op, id_rs_idx, id_rs_val, id_rt_idx, id_rt_val,
               id_cnt_from_reg, id_cnt_imm, id_rd_idx,
               stall, flush,
               exmem_wr_en, exmem_wr_idx, exmem_wr_data,
               memwb_wr_en, memwb_wr_idx, memwb_wr_data,
        output ex_valid, ex_in, ex_cnt, ex_op, ex_rd_idx, ex_fwd_rs
    );
endinterface

// File: rtl/shift_opnd_stage.sv
// ---------------------------------------------------------------------------
// shift_opnd_stage
// ID/EX pipeline register for the execute-stage shifter. Captures the shift
// operands with RAW forwarding from EX/MEM and MEM/WB, keeps snooping those
// writers while stalled, and supports flush (squash) and stall (hold).
// All outputs are registered; the shifter uses them in the following cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    shift_opnd_stage_if.slave (ID inputs, control, writers, ex_*)
//
// The interface instance must be built with the same DW/RW/CW values.
// ---------------------------------------------------------------------------
module shift_opnd_stage #(
    parameter int DW = 16,
    parameter int RW = 3,
    parameter int CW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_opnd_stage_if.slave bus
);

    // Forwarding source codes as reported on ex_fwd_rs
    localparam logic [1:0] SRC_RF    = 2'b00;
    localparam logic [1:0] SRC_MEMWB = 2'b01;
    localparam logic [1:0] SRC_EXMEM = 2'b10;

    logic          valid_q;
    logic [DW-1:0] in_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    op_q;
    logic [RW-1:0] rd_q;
    logic [1:0]    fwd_q;
    logic [RW-1:0] rs_idx_q;
    logic [RW-1:0] rt_idx_q;
    logic          cnt_from_reg_q;

    logic [1:0]    rs_fwd_code;
    logic [1:0]    rt_fwd_code;
    logic [1:0]    snoop_rs_code;
    logic [1:0]    snoop_rt_code;
    logic [DW-1:0] rs_fwd_val;
    logic [DW-1:0] rt_fwd_val;
    logic [DW-1:0] snoop_rs_val;
    logic [DW-1:0] snoop_rt_val;
    logic          unused_cnt_hi;

    // Picks the youngest writer targeting idx; EX/MEM is younger than MEM/WB
    // and therefore wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [RW-1:0] idx,
        input logic          ex_en,
        input logic [RW-1:0] ex_idx,
        input logic          mw_en,
        input logic [RW-1:0] mw_idx
    );
        if (ex_en && (ex_idx == idx)) begin
            return SRC_EXMEM;
        end else if (mw_en && (mw_idx == idx)) begin
            return SRC_MEMWB;
        end
        return SRC_RF;
    endfunction

    function automatic logic [DW-1:0] fwd_mux(
        input logic [1:0]    code,
        input logic [DW-1:0] regval,
        input logic [DW-1:0] ex_data,
        input logic [DW-1:0] mw_data
    );
        case (code)
            SRC_EXMEM: return ex_data;
            SRC_MEMWB: return mw_data;
            default:   return regval;
        endcase
    endfunction

    // Forwarded operands for a fresh capture from ID, and for snooping the
    // already-held indices while stalled. For the snoop, the "register value"
    // fallback is the currently held output so a miss simply holds.
    always_comb begin
        rs_fwd_code   = fwd_sel(bus.id_rs_idx, bus.exmem_wr_en, bus.exmem_wr_idx,
                                bus.memwb_wr_en, bus.memwb_wr_idx);
        rt_fwd_code   = fwd_sel(bus.id_rt_idx, bus.exmem_wr_en, bus.exmem_wr_idx,
                                bus.memwb_wr_en, bus.memwb_wr_idx);
        snoop_rs_code = fwd_sel(rs_idx_q, bus.exmem_wr_en, bus.exmem_wr_idx,
                                bus.memwb_wr_en, bus.memwb_wr_idx);
        snoop_rt_code = fwd_sel(rt_idx_q, bus.exmem_wr_en, bus.exmem_wr_idx,
                                bus.memwb_wr_en, bus.memwb_wr_idx);

        rs_fwd_val   = fwd_mux(rs_fwd_code, bus.id_rs_val,
                               bus.exmem_wr_data, bus.memwb_wr_data);
        rt_fwd_val   = fwd_mux(rt_fwd_code, bus.id_rt_val,
                               bus.exmem_wr_data, bus.memwb_wr_data);
        snoop_rs_val = fwd_mux(snoop_rs_code, in_q,
                               bus.exmem_wr_data, bus.memwb_wr_data);
        snoop_rt_val = fwd_mux(snoop_rt_code, {{(DW-CW){1'b0}}, cnt_q},
                               bus.exmem_wr_data, bus.memwb_wr_data);
    end

    // Only the low CW bits of a register count reach the shifter.
    assign unused_cnt_hi = ^{rt_fwd_val[DW-1:CW], snoop_rt_val[DW-1:CW]};

    // Stage register. Flush and an empty ID slot both leave a clean
    // all-zero bubble, including the hidden snoop indices. A stall holds
    // the instruction but still lets late writers refresh its operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q        <= 1'b0;
            in_q           <= '0;
            cnt_q          <= '0;
            op_q           <= '0;
            rd_q           <= '0;
            fwd_q          <= SRC_RF;
            rs_idx_q       <= '0;
            rt_idx_q       <= '0;
            cnt_from_reg_q <= 1'b0;
        end else if (bus.flush || (!bus.stall && !bus.id_valid)) begin
            valid_q        <= 1'b0;
            in_q           <= '0;
            cnt_q          <= '0;
            op_q           <= '0;
            rd_q           <= '0;
            fwd_q          <= SRC_RF;
            rs_idx_q       <= '0;
            rt_idx_q       <= '0;
            cnt_from_reg_q <= 1'b0;
        end else if (bus.stall) begin
            if (valid_q) begin
                if (snoop_rs_code != SRC_RF) begin
                    in_q  <= snoop_rs_val;
                    fwd_q <= snoop_rs_code;
                end
                if (cnt_from_reg_q && (snoop_rt_code != SRC_RF)) begin
                    cnt_q <= snoop_rt_val[CW-1:0];
                end
            end
        end else begin
            valid_q        <= 1'b1;
            in_q           <= rs_fwd_val;
            cnt_q          <= bus.id_cnt_from_reg ? rt_fwd_val[CW-1:0] : bus.id_cnt_imm;
            op_q           <= bus.id_op;
            rd_q           <= bus.id_rd_idx;
            fwd_q          <= rs_fwd_code;
            rs_idx_q       <= bus.id_rs_idx;
            rt_idx_q       <= bus.id_rt_idx;
            cnt_from_reg_q <= bus.id_cnt_from_reg;
        end
    end

    assign bus.ex_valid  = valid_q;
    assign bus.ex_in     = in_q;
    assign bus.ex_cnt    = cnt_q;
    assign bus.ex_op     = op_q;
    assign bus.ex_rd_idx = rd_q;
    assign bus.ex_fwd_rs = fwd_q;

endmodule

// File: tb/tb_shift_opnd_stage.sv
// ---------------------------------------------------------------------------
// tb_shift_opnd_stage
// Self-checking bench for shift_opnd_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// stage's contents.
// ---------------------------------------------------------------------------
module tb_shift_opnd_stage;

    localparam int DW = 16;
    localparam int RW = 3;
    localparam int CW = 4;

    logic clk;
    logic rst_n;
    int   assertCount;
    int   failCount;

    shift_opnd_stage_if #(.DW(DW), .RW(RW), .CW(CW)) bus ();

    shift_opnd_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // What the stage should hold: the live instruction's operands plus the
    // indices it must keep watching while stalled.
    typedef struct {
        logic          v;
        logic [DW-1:0] in;
        logic [CW-1:0] cnt;
        logic [1:0]    op;
        logic [RW-1:0] rd;
        logic [1:0]    src;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic          cfr;
    } model_t;

    model_t m;

    // Compares one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".valid"}, 32'(bus.ex_valid),  32'(m.v));
        checkOutput({tag, ".in"},    32'(bus.ex_in),     32'(m.in));
        checkOutput({tag, ".cnt"},   32'(bus.ex_cnt),    32'(m.cnt));
        checkOutput({tag, ".op"},    32'(bus.ex_op),     32'(m.op));
        checkOutput({tag, ".rd"},    32'(bus.ex_rd_idx), 32'(m.rd));
        checkOutput({tag, ".src"},   32'(bus.ex_fwd_rs), 32'(m.src));
    endtask

    function automatic model_t emptyModel();
        model_t e;
        e.v = 1'b0; e.in = '0; e.cnt = '0; e.op = '0; e.rd = '0;
        e.src = '0; e.rs = '0; e.rt = '0; e.cfr = 1'b0;
        return e;
    endfunction

    // Value of register idx as the instruction should see it: scan the
    // in-flight writers youngest first; the first one targeting idx supplies it.
    task automatic lookup(input logic [RW-1:0] idx, input logic [DW-1:0] regval,
                          output logic [DW-1:0] val, output logic [1:0] src, output bit hit);
        logic          wen  [2];
        logic [RW-1:0] widx [2];
        logic [DW-1:0] wdat [2];
        logic [1:0]    wsrc [2];
        wen[0] = bus.exmem_wr_en; widx[0] = bus.exmem_wr_idx; wdat[0] = bus.exmem_wr_data; wsrc[0] = 2'd2;
        wen[1] = bus.memwb_wr_en; widx[1] = bus.memwb_wr_idx; wdat[1] = bus.memwb_wr_data; wsrc[1] = 2'd1;
        val = regval;
        src = 2'd0;
        hit = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (!hit && wen[w] && widx[w] == idx) begin
                val = wdat[w];
                src = wsrc[w];
                hit = 1'b1;
            end
        end
    endtask

    // Model of one clock edge from the inputs currently on the bus
    task automatic modelEdge();
        logic [DW-1:0] v;
        logic [1:0]    s;
        bit            h;
        if (bus.flush) begin
            m = emptyModel();
        end else if (bus.stall) begin
            if (m.v) begin
                lookup(m.rs, m.in, v, s, h);
                if (h) begin
                    m.in  = v;
                    m.src = s;
                end
                if (m.cfr) begin
                    lookup(m.rt, DW'(m.cnt), v, s, h);
                    if (h) m.cnt = v[CW-1:0];
                end
            end
        end else if (!bus.id_valid) begin
            m = emptyModel();
        end else begin
            lookup(bus.id_rs_idx, bus.id_rs_val, v, s, h);
            m.v   = 1'b1;
            m.in  = v;
            m.src = s;
            if (bus.id_cnt_from_reg) begin
                lookup(bus.id_rt_idx, bus.id_rt_val, v, s, h);
                m.cnt = v[CW-1:0];
            end else begin
                m.cnt = bus.id_cnt_imm;
            end
            m.op  = bus.id_op;
            m.rd  = bus.id_rd_idx;
            m.rs  = bus.id_rs_idx;
            m.rt  = bus.id_rt_idx;
            m.cfr = bus.id_cnt_from_reg;
        end
    endtask

    // Advance one edge and check all outputs #1 after it
    task automatic stepCycle(input string tag);
        modelEdge();
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    task automatic clearInputs();
        bus.id_valid = 0; bus.id_op = '0; bus.id_rs_idx = '0; bus.id_rs_val = '0;
        bus.id_rt_idx = '0; bus.id_rt_val = '0; bus.id_cnt_from_reg = 0;
        bus.id_cnt_imm = '0; bus.id_rd_idx = '0; bus.stall = 0; bus.flush = 0;
        bus.exmem_wr_en = 0; bus.exmem_wr_idx = '0; bus.exmem_wr_data = '0;
        bus.memwb_wr_en = 0; bus.memwb_wr_idx = '0; bus.memwb_wr_data = '0;
    endtask

    // Random traffic; small index ranges keep forwarding hits frequent
    task automatic applyStimulus();
        bus.id_valid        = ($urandom_range(0, 3) != 0);
        bus.id_op           = 2'($urandom_range(0, 3));
        bus.id_rs_idx       = RW'($urandom_range(0, 3));
        bus.id_rs_val       = DW'($urandom);
        bus.id_rt_idx       = RW'($urandom_range(0, 3));
        bus.id_rt_val       = DW'($urandom);
        bus.id_cnt_from_reg = $urandom_range(0, 1) == 1;
        bus.id_cnt_imm      = CW'($urandom);
        bus.id_rd_idx       = RW'($urandom);
        bus.stall           = ($urandom_range(0, 3) == 0);
        bus.flush           = ($urandom_range(0, 9) == 0);
        bus.exmem_wr_en     = $urandom_range(0, 1) == 1;
        bus.exmem_wr_idx    = RW'($urandom_range(0, 3));
        bus.exmem_wr_data   = DW'($urandom);
        bus.memwb_wr_en     = $urandom_range(0, 1) == 1;
        bus.memwb_wr_idx    = RW'($urandom_range(0, 3));
        bus.memwb_wr_data   = DW'($urandom);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        m = emptyModel();
        clearInputs();
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        rst_n = 1'b1;
        stepCycle("idle");

        // Reset mid-operation: load, then drop rst_n between edges
        bus.id_valid = 1; bus.id_rs_idx = 3'd6; bus.id_rs_val = 16'h1234;
        bus.id_op = 2'b01; bus.id_cnt_imm = 4'd3; bus.id_rd_idx = 3'd2;
        stepCycle("pre_reset_load");
        #2;
        rst_n = 1'b0;
        #1;
        m = emptyModel();
        checkAll("async_reset");
        clearInputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stepCycle("post_reset");

        // Plain load, no writers
        clearInputs();
        bus.id_valid = 1; bus.id_rs_val = 16'h8001; bus.id_cnt_imm = 4'd1;
        bus.id_op = 2'b00; bus.id_rd_idx = 3'd5; bus.id_rs_idx = 3'd7;
        stepCycle("plain_load");
        checkOutput("plain_in", 32'(bus.ex_in), 32'h8001);

        // Dual-match priority, then MEM/WB only
        clearInputs();
        bus.id_valid = 1; bus.id_rs_idx = 3'd2; bus.id_rs_val = 16'h1111;
        bus.exmem_wr_en = 1; bus.exmem_wr_idx = 3'd2; bus.exmem_wr_data = 16'hAAAA;
        bus.memwb_wr_en = 1; bus.memwb_wr_idx = 3'd2; bus.memwb_wr_data = 16'h5555;
        stepCycle("dual_match");
        checkOutput("dual_in", 32'(bus.ex_in), 32'hAAAA);
        checkOutput("dual_src", 32'(bus.ex_fwd_rs), 32'h2);
        bus.exmem_wr_en = 0;
        stepCycle("memwb_only");
        checkOutput("memwb_in", 32'(bus.ex_in), 32'h5555);
        checkOutput("memwb_src", 32'(bus.ex_fwd_rs), 32'h1);

        // Register count forwarded from MEM/WB, upper bits dropped
        clearInputs();
        bus.id_valid = 1; bus.id_cnt_from_reg = 1; bus.id_rt_idx = 3'd4;
        bus.id_rt_val = 16'h0003; bus.id_cnt_imm = 4'd9;
        bus.memwb_wr_en = 1; bus.memwb_wr_idx = 3'd4; bus.memwb_wr_data = 16'hFFF7;
        stepCycle("reg_cnt");
        checkOutput("reg_cnt_val", 32'(bus.ex_cnt), 32'h7);

        // Stall snoop: capture R1, stall two cycles, MEM/WB writes R1 in the second
        clearInputs();
        bus.id_valid = 1; bus.id_rs_idx = 3'd1; bus.id_rs_val = 16'h0F0F;
        bus.id_op = 2'b11; bus.id_rd_idx = 3'd3; bus.id_cnt_imm = 4'd2;
        stepCycle("snoop_capture");
        bus.stall = 1; bus.id_valid = 0; bus.id_op = 2'b00; bus.id_rd_idx = 3'd6;
        stepCycle("snoop_stall1");
        bus.memwb_wr_en = 1; bus.memwb_wr_idx = 3'd1; bus.memwb_wr_data = 16'h00FF;
        stepCycle("snoop_stall2");
        checkOutput("snoop_in", 32'(bus.ex_in), 32'h00FF);
        checkOutput("snoop_src", 32'(bus.ex_fwd_rs), 32'h1);
        checkOutput("snoop_op", 32'(bus.ex_op), 32'h3);
        checkOutput("snoop_rd", 32'(bus.ex_rd_idx), 32'h3);

        // Flush beats stall, then a bubble stays a bubble
        bus.flush = 1;
        stepCycle("flush_stall");
        checkOutput("flush_valid", 32'(bus.ex_valid), 32'h0);
        clearInputs();
        stepCycle("flush_bubble");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus();
            stepCycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
